// File: rtl/operand_select_buffer_pkg.sv
// Shared constants for the ALU source-B operand selector: slot indices of the
// datapath instance, default data width and transfer-counter width.
package operand_select_buffer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int XFER_W        = 16;

  typedef enum logic [2:0] {
    SLOT_B       = 3'd0,
    SLOT_FOUR    = 3'd1,
    SLOT_SIGNEXT = 3'd2,
    SLOT_ADDR    = 3'd3,
    SLOT_MDR     = 3'd4
  } alu_b_slot_e;

  localparam int DEFAULT_NUM_SRC   = 5;
  localparam int DEFAULT_CONST_IDX = 1;
  localparam int DEFAULT_CONST_VAL = 4;

endpackage

// File: rtl/operand_select_buffer_skid_buffer_2.sv
// Generic 2-entry valid/ready stage: a main register driving the outputs plus a
// skid register, so in_ready is a flop with no path from out_ready.
module skid_buffer_2
  import operand_select_buffer_pkg::*;
#(
  parameter int P_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_data
);

  logic           main_vld_q, main_vld_d;
  logic           skid_vld_q, skid_vld_d;
  logic [P_W-1:0] main_q, main_d;
  logic [P_W-1:0] skid_q, skid_d;
  logic           in_fire, out_fire;

  assign in_fire  = in_valid && !skid_vld_q;
  assign out_fire = main_vld_q && out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || out_fire) begin
      // A full skid blocks the input, so draining it never races a new request.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_d     = in_fire ? in_data : main_q;
        main_vld_d = in_fire;
      end
    end else if (in_fire) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

endmodule

// File: rtl/operand_select_buffer.sv
// Registered ALU source-B operand selector with constant slot and skid-buffered
// output. Define OPSEL_ILLEGAL_CHK_EN to build the sticky out-of-range flag.
module operand_select_buffer
  import operand_select_buffer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NUM_SRC   = DEFAULT_NUM_SRC,
  parameter int SEL_W     = 3,
  parameter int CONST_IDX = DEFAULT_CONST_IDX,
  parameter int CONST_VAL = DEFAULT_CONST_VAL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     err_illegal,
  input  logic                     err_clear,
  output logic [XFER_W-1:0]        xfer_count
);

  localparam int P_W = SEL_W + WIDTH;

  logic [WIDTH-1:0]  sel_data;
  logic [P_W-1:0]    out_payload;
  logic [XFER_W-1:0] xfer_count_q, xfer_count_d;
  logic              unused_const_slot;

  // Out-of-range selects fall through every comparison and leave zero data.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = (k == CONST_IDX) ? WIDTH'(CONST_VAL) : src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign unused_const_slot = ^src_data[CONST_IDX*WIDTH +: WIDTH];

  skid_buffer_2 #(.P_W(P_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sel, sel_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_sel, out_data} = out_payload;

  always_comb begin
    xfer_count_d = xfer_count_q + XFER_W'(out_valid && out_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xfer_count_q <= '0;
    else        xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;

`ifdef OPSEL_ILLEGAL_CHK_EN
  logic err_q, err_d;
  logic illegal_fire;

  assign illegal_fire = in_valid && in_ready && (int'(in_sel) >= NUM_SRC);

  // A new illegal accept outranks a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (illegal_fire)   err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_illegal = err_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign err_illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_operand_select_buffer.sv
// Scoreboard bench for operand_select_buffer: directed cases, random traffic,
// async reset during a stall and xfer_count wrap.
module tb_operand_select_buffer;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 5;
  localparam int SEL_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     err_illegal;
  logic                     err_clear;
  logic [15:0]              xfer_count;

  operand_select_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .src_data    (src_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .err_illegal (err_illegal),
    .err_clear   (err_clear),
    .xfer_count  (xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] xfer_m = 0;
  logic        err_m  = 0;

`ifdef OPSEL_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_operand(input int sel, input logic [NUM_SRC*WIDTH-1:0] src);
    if (sel >= NUM_SRC) return '0;
    if (sel == 1) return 32'd4;
    return src[sel*WIDTH +: WIDTH];
  endfunction

  // Monitor: in_ready/out_valid/xfer/err follow from the number of entries in
  // flight and the transfer history; data/sel compare against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_sel", out_sel, 0);
      check("rst_err", err_illegal, 0);
      check("rst_xfer", xfer_count, 0);
      q.delete();
      xfer_m = 0;
      err_m  = 0;
    end else begin
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() != 0);
      check("xfer_count", xfer_count, xfer_m);
      check("err_illegal", err_illegal, err_m);
      if (out_valid && q.size() != 0) begin
        check("out_data", out_data, q[0].d);
        check("out_sel", out_sel, q[0].s);
        if (out_ready) begin
          void'(q.pop_front());
          xfer_m = xfer_m + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.d = ref_operand(int'(in_sel), src_data);
        e.s = in_sel;
        q.push_back(e);
      end
      if (CHK) begin
        if (in_valid && in_ready && int'(in_sel) >= NUM_SRC) err_m = 1'b1;
        else if (err_clear)                                 err_m = 1'b0;
      end
    end
  end

  task automatic randomize_src();
    for (int k = 0; k < NUM_SRC; k++) src_data[k*WIDTH +: WIDTH] = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check(name, q.size(), 0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd2;
    out_ready = 1'b1;
    err_clear = 1'b0;
    randomize_src();
    repeat (4) step();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();

    // Basic select of slot 2
    randomize_src();
    src_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    in_sel = 3'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    randomize_src();
    step();
    check("xfer_after_basic", xfer_count, 1);

    // Constant slot ignores its src_data
    src_data[1*WIDTH +: WIDTH] = 32'hFFFFFFFF;
    in_sel = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    drain("drain_const");

    // Backpressure: 10, 20, 30 with out_ready low for two cycles
    in_valid = 1'b1; in_sel = 3'd0; src_data[0 +: WIDTH] = 32'd10; out_ready = 1'b1;
    step();
    in_sel = 3'd2; src_data[2*WIDTH +: WIDTH] = 32'd20; out_ready = 1'b0;
    step();
    check("bp_in_ready_low", in_ready, 0);
    in_sel = 3'd3; src_data[3*WIDTH +: WIDTH] = 32'd30;
    step();
    out_ready = 1'b1;
    step();
    check("bp_in_ready_high", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain("drain_bp");
    check("bp_xfer_total", xfer_count, 5);

    // Illegal selects and err_clear priority
    in_valid = 1'b1; in_sel = 3'd6;
    step();
    in_valid = 1'b0;
    step(); step();
    check("err_set", err_illegal, CHK);
    in_valid = 1'b1; in_sel = 3'd7; err_clear = 1'b1;
    step();
    in_valid = 1'b0; err_clear = 1'b0;
    step();
    check("err_set_wins", err_illegal, CHK);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    check("err_cleared", err_illegal, 0);
    drain("drain_illegal");

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sel    = SEL_W'($urandom % 8);
      out_ready = ($urandom % 4) != 0;
      err_clear = ($urandom % 8) == 0;
      randomize_src();
      step();
    end
    err_clear = 1'b0;
    drain("drain_random");

    // Async reset while both entries are full
    in_valid = 1'b1; in_sel = 3'd4; out_ready = 1'b0;
    repeat (3) begin
      randomize_src();
      step();
    end
    check("stall_full", in_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_out_data", out_data, 0);
    step();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // 65536 transfers wrap the counter back to zero
    in_valid = 1'b1; in_sel = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    in_valid = 1'b0;
    step(); step();
    check("xfer_wrap", xfer_count, 16'h0000);
    check("wrap_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_select_buffer.md
# operand_select_buffer

Parametrised, registered operand selector for the multicycle datapath: picks one of `NUM_SRC` data sources, or a built-in constant slot, per request, and delivers the result through a 2-entry skid buffer with valid/ready handshake. It generalises the ALU source-B mux: configurable width and source count, defined behaviour for every select code, and a stall-tolerant output stage. It sits between the register-file and immediate paths and the ALU operand port.

## Interface
- `WIDTH`, 32, data width of every source and of the output.
- `NUM_SRC`, 5, number of selectable slots (2..16), including the constant slot.
- `SEL_W`, 3, select width; must satisfy 2**SEL_W >= NUM_SRC.
- `CONST_IDX`, 1, slot index that returns `CONST_VAL` instead of `src_data`.
- `CONST_VAL`, 4, constant driven for `CONST_IDX`, zero-extended to `WIDTH`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_sel`  in  SEL_W  slot index.
- `src_data`  in  NUM_SRC*WIDTH  flattened sources; slot k is bits [k*WIDTH +: WIDTH].
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  selected operand.
- `out_sel`  out  SEL_W  slot index the result came from.
- `err_illegal`  out  1  sticky: an out-of-range select was accepted.
- `err_clear`  in  1  clears `err_illegal`.
- `xfer_count`  out  16  number of output transfers, wrapping.

## Operation
- Input fires on `in_valid && in_ready`; output fires on `out_valid && out_ready`.
- Selection happens at input fire. The selected value is captured, so later changes to `src_data` do not affect it.
- Slot `CONST_IDX` yields `CONST_VAL`. Any other slot below `NUM_SRC` yields that slot's `src_data`.
- A select ≥ `NUM_SRC` is accepted, never dropped. It yields all-zero data and carries its `out_sel` unchanged.
- Storage is a main register (drives outputs) plus a skid register:
  - Main empty, or main firing: main loads from the skid if the skid is full, otherwise from the input.
  - Input fires while main is full and not firing: the result goes to the skid.
  - Ordering is strict FIFO.
- `in_ready` is `!skid_valid`, registered; it depends on no combinational path from `out_ready`.
- `xfer_count` increments on each output fire and wraps 0xFFFF→0x0000.
- `err_clear` and a new illegal accept in the same cycle: the flag stays set (set wins).

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=0, `out_sel`=0, `err_illegal`=0, `xfer_count`=0; skid empty.
- Latency: input fire in cycle N gives `out_valid` in cycle N+1.
- Throughput: 1 result/cycle while `out_ready`=1.
- `out_ready` low for one cycle with continuous input:
  - one result lands in the skid;
  - `in_ready` falls the next cycle;
  - it rises again one cycle after the skid drains.
- Simultaneous input fire and output fire with main full and skid empty: main reloads directly from the input; the skid stays empty.
- `out_data` and `out_sel` are stable while `out_valid && !out_ready`.
- Reset asserted mid-operation discards both entries immediately, asynchronously; no partial transfer completes.

## Configuration
- `OPSEL_ILLEGAL_CHK_EN` defined: out-of-range selects set `err_illegal`, and `err_clear` is functional.
- Not defined:
  - `err_illegal` is tied to 0 and `err_clear` is ignored;
  - out-of-range selects still yield zero data;
  - no check logic is synthesised.

## Structure
- Shared package holds:
  - the slot-index constants for the datapath instance (B=0, FOUR=1, SIGNEXT=2, ADDR=3, MDR=4);
  - the default `WIDTH`;
  - the `xfer_count` width constant.
- One sub-module, `skid_buffer_2`:
  - generic 2-entry valid/ready stage, carrying `{out_sel, data}` as the payload;
  - selection and error logic stay in the top module.

## Test plan
- Reset: hold `reset`=0 with `in_valid`=1 → all outputs at reset values, `in_ready`=1, nothing delivered.
- Basic select: `in_sel`=2, slot 2=0xDEADBEEF, `out_ready`=1 → cycle N+1 `out_data`=0xDEADBEEF, `out_sel`=2, `xfer_count`=1.
- Constant slot: `in_sel`=1 with slot-1 input 0xFFFFFFFF → `out_data`=0x00000004.
- Backpressure: stream selects 0,2,3 with values 10,20,30; drop `out_ready` for 2 cycles after the first result:
  - `in_ready` falls once the skid fills;
  - outputs arrive in order 10,20,30 with none lost or duplicated.
- Illegal select (macro on): `in_sel`=6 → `out_data`=0, `out_sel`=6, `err_illegal`=1 and stays 1. `err_clear` in the same cycle as another illegal accept leaves it 1; `err_clear` alone clears it.
- Wrap: preset via 65 536 output transfers → `xfer_count` returns to 0x0000. Async reset during a stall empties both entries and sets `out_valid`=0 without waiting for a clock.
